pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and stall scheduler for the five-stage pipelined RV32I core. It sits beside the pipeline registers and decides each cycle which stages advance, which are flushed and which operand sources the Execute stage uses. It covers register forwarding, load-use stalls, branch/jump flushes and data-memory wait states, including a wait-timeout fault.

Parameters:
- TIMEOUT_CYCLES, 64: maximum consecutive memory-wait cycles before a fault is declared.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- iClk  in  1  core clock.
- iRst  in  1  asynchronous, active-high reset.
- iRs1D, iRs2D  in  5  source registers in Decode.
- iRs1E, iRs2E, iRdE  in  5  source and destination registers in Execute.
- iResultSrcE  in  3  Execute result-source field; a load is indicated by RESULT_SRC_LOAD.
- iPCSrcE  in  1  branch taken or jump resolved in Execute.
- iRdM  in  5  destination register in Memory.
- iRegWriteM  in  1  register write enable in Memory.
- iMemReqM  in  1  load or store active in Memory.
- iMemReadyM  in  1  data memory has completed the access this cycle.
- iRdW  in  5  destination register in Writeback.
- iRegWriteW  in  1  register write enable in Writeback.
- oForwardAE, oForwardBE  out  2  Execute operand source select.
- oStallF, oStallD, oStallE, oStallM  out  1  hold the corresponding pipeline register.
- oFlushD, oFlushE  out  1  clear the corresponding pipeline register to a NOP.
- oBubbleW  out  1  write a NOP into the M/W register.
- oMemFault  out  1  sticky memory-timeout fault.

Behaviour:
- Reset: FSM goes to IDLE, counter to 0, oMemFault to 0. While iRst is high, all stall, flush, bubble and forward outputs are 0.
- Forwarding (combinational), evaluated for operand A against iRs1E and operand B against iRs2E:
  - FWD_MEM (2'b10) if iRegWriteM, iRdM≠0 and iRdM matches the source register.
  - Otherwise FWD_WB (2'b01) if iRegWriteW, iRdW≠0 and iRdW matches the source register.
  - Otherwise FWD_NONE (2'b00).
  - Memory has priority over Writeback when both match.
- Load-use: lu = (iResultSrcE==RESULT_SRC_LOAD) & iRdE≠0 & (iRdE==iRs1D | iRdE==iRs2D).
- Memory-wait FSM states: IDLE, WAIT, FAULT.
  - IDLE→WAIT when iMemReqM & !iMemReadyM; the counter loads 1.
  - WAIT→IDLE when iMemReadyM; the counter clears.
  - WAIT→FAULT when the counter == TIMEOUT_CYCLES and !iMemReadyM; otherwise the counter increments.
  - FAULT is absorbing until reset; oMemFault is 1 in FAULT.
- memStall = (IDLE & iMemReqM & !iMemReadyM) | (WAIT & !iMemReadyM) | FAULT. It is combinational, so a ready response in the same cycle never stalls.
- Output priority, highest first:
  1. memStall: oStallF=oStallD=oStallE=oStallM=1 and oBubbleW=1. oFlushD=oFlushE=0; lu and iPCSrcE are ignored. Execute is frozen, so a pending iPCSrcE persists and is acted on after release.
  2. iPCSrcE: oFlushD=oFlushE=1 and no stalls. A branch overrides a simultaneous load-use, because the Decode instruction is discarded.
  3. lu: oStallF=oStallD=1 and oFlushE=1. Exactly one bubble is inserted.
  4. Otherwise all outputs are 0.
- x0 is never a hazard source or destination.
- Reset mid-WAIT returns the FSM to IDLE immediately (asynchronous reset).

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, three 32-bit outputs are added:
  - oStallCycles: counts cycles with any oStall* asserted.
  - oFlushCount: counts cycles with oFlushE asserted.
  - oLoadUseCount: counts cycles where load-use is the winning priority.
  - All three saturate at 32'hFFFFFFFF and clear on iRst.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - typedef ForwardSel (FWD_NONE, FWD_WB, FWD_MEM).
  - typedef MemWaitState (IDLE, WAIT, FAULT).
  - constant RESULT_SRC_LOAD = 3'b001.
- One sub-module, hazard_mem_wait_fsm, contains the FSM and counter and outputs memStall and oMemFault. Forwarding, load-use and priority logic stay in the top module.

Test Plan:
- Forwarding priority: RdM=5 RegWriteM=1, RdW=5 RegWriteW=1, Rs1E=5 → oForwardAE=2'b10. With RdM=0 → 2'b01. With Rs1E=0 and both Rd=0 → 2'b00.
- Load-use: ResultSrcE=3'b001, RdE=7, Rs2D=7 → exactly one cycle of oStallF=oStallD=oFlushE=1, then all outputs 0.
- Branch over load-use: the load-use condition above plus iPCSrcE=1 → oFlushD=oFlushE=1 and oStallF=0.
- Memory wait: iMemReqM=1 with iMemReadyM low for 3 cycles, then high → all four stalls and oBubbleW high for exactly 3 cycles, released in the ready cycle, FSM back to IDLE.
- Timeout with TIMEOUT_CYCLES=4: ready held low → oMemFault rises after the 5th wait cycle and stays high with ready=1. Asserting iRst asynchronously clears it.
- Simultaneous memory stall and iPCSrcE=1 for 2 cycles → no flush during the stall; flushes assert in the first cycle after release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Consumers: pipeline_hazard_ctrl and hazard_mem_wait_fsm.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } ForwardSel;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        FAULT = 2'b10
    } MemWaitState;

    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    // Memory stage wins over Writeback; x0 never forwards.
    function automatic ForwardSel fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
        if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
        return FWD_NONE;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Data-memory wait-state tracker: raises a combinational stall while an access
// is outstanding and latches a sticky fault once the wait exceeds TIMEOUT_CYCLES.
module hazard_mem_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iMemReqM,
    input  logic iMemReadyM,
    output logic oMemStall,
    output logic oMemFault
);

    MemWaitState            state_q, state_d;
    logic       [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A ready response in the same cycle never stalls, so the stall is decoded from inputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oMemStall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iMemReqM && !iMemReadyM) begin
                    state_d   = WAIT;
                    cnt_d     = CNT_W'(1);
                    oMemStall = 1'b1;
                end
            end
            WAIT: begin
                if (iMemReadyM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    oMemStall = 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d = FAULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                oMemStall = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign oMemFault = (state_q == FAULT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler for the five-stage RV32I pipeline.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush/load-use counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [4:0]  iRs1D,
    input  logic [4:0]  iRs2D,
    input  logic [4:0]  iRs1E,
    input  logic [4:0]  iRs2E,
    input  logic [4:0]  iRdE,
    input  logic [2:0]  iResultSrcE,
    input  logic        iPCSrcE,
    input  logic [4:0]  iRdM,
    input  logic        iRegWriteM,
    input  logic        iMemReqM,
    input  logic        iMemReadyM,
    input  logic [4:0]  iRdW,
    input  logic        iRegWriteW,
    output logic [1:0]  oForwardAE,
    output logic [1:0]  oForwardBE,
    output logic        oStallF,
    output logic        oStallD,
    output logic        oStallE,
    output logic        oStallM,
    output logic        oFlushD,
    output logic        oFlushE,
    output logic        oBubbleW,
`ifdef HAZARD_STATS_EN
    output logic [31:0] oStallCycles,
    output logic [31:0] oFlushCount,
    output logic [31:0] oLoadUseCount,
`endif
    output logic        oMemFault
);

    logic      mem_stall;
    logic      load_use;
    logic      load_use_win;
    ForwardSel fwd_a, fwd_b;

    hazard_mem_wait_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_mem_wait (
        .iClk       (iClk),
        .iRst       (iRst),
        .iMemReqM   (iMemReqM),
        .iMemReadyM (iMemReadyM),
        .oMemStall  (mem_stall),
        .oMemFault  (oMemFault)
    );

    always_comb begin
        fwd_a    = fwd_select(iRs1E, iRdM, iRegWriteM, iRdW, iRegWriteW);
        fwd_b    = fwd_select(iRs2E, iRdM, iRegWriteM, iRdW, iRegWriteW);
        load_use = (iResultSrcE == RESULT_SRC_LOAD) && (iRdE != 5'd0)
                   && ((iRdE == iRs1D) || (iRdE == iRs2D));
    end

    // Priority: memory stall freezes everything, then redirect, then load-use bubble.
    always_comb begin
        oForwardAE   = 2'b00;
        oForwardBE   = 2'b00;
        oStallF      = 1'b0;
        oStallD      = 1'b0;
        oStallE      = 1'b0;
        oStallM      = 1'b0;
        oFlushD      = 1'b0;
        oFlushE      = 1'b0;
        oBubbleW     = 1'b0;
        load_use_win = 1'b0;
        if (!iRst) begin
            oForwardAE = fwd_a;
            oForwardBE = fwd_b;
            if (mem_stall) begin
                oStallF  = 1'b1;
                oStallD  = 1'b1;
                oStallE  = 1'b1;
                oStallM  = 1'b1;
                oBubbleW = 1'b1;
            end else if (iPCSrcE) begin
                oFlushD = 1'b1;
                oFlushE = 1'b1;
            end else if (load_use) begin
                oStallF      = 1'b1;
                oStallD      = 1'b1;
                oFlushE      = 1'b1;
                load_use_win = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] load_use_count_q, load_use_count_d;

    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        flush_count_d    = flush_count_q;
        load_use_count_d = load_use_count_q;
        if (oStallF || oStallD || oStallE || oStallM) stall_cycles_d = sat_inc(stall_cycles_q);
        if (oFlushE) flush_count_d = sat_inc(flush_count_q);
        if (load_use_win) load_use_count_d = sat_inc(load_use_count_q);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stall_cycles_q   <= '0;
            flush_count_q    <= '0;
            load_use_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            flush_count_q    <= flush_count_d;
            load_use_count_q <= load_use_count_d;
        end
    end

    assign oStallCycles  = stall_cycles_q;
    assign oFlushCount   = flush_count_q;
    assign oLoadUseCount = load_use_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [4:0]  iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW;
    logic [2:0]  iResultSrcE;
    logic        iPCSrcE, iRegWriteM, iMemReqM, iMemReadyM, iRegWriteW;
    logic [1:0]  oForwardAE, oForwardBE;
    logic        oStallF, oStallD, oStallE, oStallM;
    logic        oFlushD, oFlushE, oBubbleW, oMemFault;
`ifdef HAZARD_STATS_EN
    logic [31:0] oStallCycles, oFlushCount, oLoadUseCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: are we in a wait, how long, has it timed out
    bit mPending;
    bit mFault;
    int mWaitCycles;
    int mStallCnt, mFlushCnt, mLuCnt;

    pipeline_hazard_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (3)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iRs1D         (iRs1D),
        .iRs2D         (iRs2D),
        .iRs1E         (iRs1E),
        .iRs2E         (iRs2E),
        .iRdE          (iRdE),
        .iResultSrcE   (iResultSrcE),
        .iPCSrcE       (iPCSrcE),
        .iRdM          (iRdM),
        .iRegWriteM    (iRegWriteM),
        .iMemReqM      (iMemReqM),
        .iMemReadyM    (iMemReadyM),
        .iRdW          (iRdW),
        .iRegWriteW    (iRegWriteW),
        .oForwardAE    (oForwardAE),
        .oForwardBE    (oForwardBE),
        .oStallF       (oStallF),
        .oStallD       (oStallD),
        .oStallE       (oStallE),
        .oStallM       (oStallM),
        .oFlushD       (oFlushD),
        .oFlushE       (oFlushE),
        .oBubbleW      (oBubbleW),
`ifdef HAZARD_STATS_EN
        .oStallCycles  (oStallCycles),
        .oFlushCount   (oFlushCount),
        .oLoadUseCount (oLoadUseCount),
`endif
        .oMemFault     (oMemFault)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] expFwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (iRegWriteM && iRdM == rs) return 2'b10;
        if (iRegWriteW && iRdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit modelMemStall();
        return mFault || (!iMemReadyM && (mPending || iMemReqM));
    endfunction

    // Packed view: {stallF,stallD,stallE,stallM,flushD,flushE,bubbleW,fault,fwdA,fwdB}
    function automatic logic [11:0] expectedCtrl();
        bit stall, lu;
        logic [11:0] e;
        e = '0;
        if (iRst) return e;
        stall = modelMemStall();
        lu = (iResultSrcE == 3'b001) && (iRdE != 5'd0) && ((iRdE == iRs1D) || (iRdE == iRs2D));
        if (stall)        e[11:5] = 7'b1111_001;
        else if (iPCSrcE) e[11:5] = 7'b0000_110;
        else if (lu)      e[11:5] = 7'b1100_010;
        e[4]   = mFault;
        e[3:2] = expFwd(iRs1E);
        e[1:0] = expFwd(iRs2E);
        return e;
    endfunction

    function automatic logic [11:0] observedCtrl();
        return {oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oBubbleW, oMemFault,
                oForwardAE, oForwardBE};
    endfunction

    function automatic int satInc(input int v);
        return (v == -1) ? v : v + 1;
    endfunction

    task automatic modelReset();
        mPending = 0;
        mFault = 0;
        mWaitCycles = 0;
        mStallCnt = 0;
        mFlushCnt = 0;
        mLuCnt = 0;
    endtask

    task automatic checkStats(input string tag);
`ifdef HAZARD_STATS_EN
        checkOutput({tag, ".stallCycles"}, oStallCycles, mStallCnt);
        checkOutput({tag, ".flushCount"}, oFlushCount, mFlushCnt);
        checkOutput({tag, ".loadUseCount"}, oLoadUseCount, mLuCnt);
`endif
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic stepCycle(input string tag);
        logic [11:0] exp;
        bit stall;
        #1;
        exp = expectedCtrl();
        stall = modelMemStall();
        checkOutput(tag, {20'd0, observedCtrl()}, {20'd0, exp});
        @(posedge iClk);
        if (exp[11] | exp[10] | exp[9] | exp[8]) mStallCnt = satInc(mStallCnt);
        if (exp[6]) mFlushCnt = satInc(mFlushCnt);
        if (exp[11:5] == 7'b1100_010) mLuCnt = satInc(mLuCnt);
        if (!mFault) begin
            if (stall) begin
                mPending = 1;
                mWaitCycles++;
                if (mWaitCycles > TIMEOUT) mFault = 1;
            end else begin
                mPending = 0;
                mWaitCycles = 0;
            end
        end
        @(negedge iClk);
        checkStats(tag);
    endtask

    task automatic clearInputs();
        {iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW} = '0;
        iResultSrcE = 3'b000;
        {iPCSrcE, iRegWriteM, iMemReqM, iRegWriteW} = '0;
        iMemReadyM = 1'b1;
    endtask

    // Asserts reset between clock edges to exercise the asynchronous path
    task automatic pulseReset(input string tag);
        #2 iRst = 1'b1;
        modelReset();
        #1;
        checkOutput({tag, ".ctrl"}, {20'd0, observedCtrl()}, 32'd0);
        checkStats(tag);
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic applyStimulus();
        iRs1D = 5'($urandom_range(0, 3));
        iRs2D = 5'($urandom_range(0, 3));
        iRs1E = 5'($urandom_range(0, 3));
        iRs2E = 5'($urandom_range(0, 3));
        iRdE  = 5'($urandom_range(0, 3));
        iRdM  = 5'($urandom_range(0, 3));
        iRdW  = 5'($urandom_range(0, 3));
        iResultSrcE = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'($urandom_range(0, 7));
        iPCSrcE    = ($urandom_range(0, 7) == 0);
        iRegWriteM = 1'($urandom_range(0, 1));
        iRegWriteW = 1'($urandom_range(0, 1));
        iMemReqM   = 1'($urandom_range(0, 1));
        iMemReadyM = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        modelReset();
        clearInputs();
        iRst = 1'b1;
        // Hazard-looking inputs must stay silent while reset is held
        iRegWriteM = 1'b1; iRdM = 5'd5; iRs1E = 5'd5;
        iMemReqM = 1'b1; iMemReadyM = 1'b0; iPCSrcE = 1'b1;
        #3;
        checkOutput("reset.ctrl", {20'd0, observedCtrl()}, 32'd0);
        checkStats("reset");
        @(negedge iClk);
        iRst = 1'b0;
        clearInputs();

        iRegWriteM = 1'b1; iRdM = 5'd5; iRegWriteW = 1'b1; iRdW = 5'd5; iRs1E = 5'd5;
        stepCycle("fwd.memPriority");
        iRdM = 5'd0;
        stepCycle("fwd.wb");
        iRs1E = 5'd0; iRdW = 5'd0;
        stepCycle("fwd.none");
        iRdM = 5'd9; iRs2E = 5'd9; iRegWriteM = 1'b0;
        stepCycle("fwd.noWriteEnable");
        clearInputs();

        iResultSrcE = 3'b001; iRdE = 5'd7; iRs2D = 5'd7;
        stepCycle("loadUse.stall");
        clearInputs();
        stepCycle("loadUse.released");
        iResultSrcE = 3'b001; iRdE = 5'd0; iRs1D = 5'd0;
        stepCycle("loadUse.x0");
        iResultSrcE = 3'b001; iRdE = 5'd7; iRs2D = 5'd7; iPCSrcE = 1'b1;
        stepCycle("branchOverLoadUse");
        clearInputs();

        iMemReqM = 1'b1; iMemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle("memWait.stall");
        iMemReadyM = 1'b1;
        stepCycle("memWait.readyCycle");
        iMemReqM = 1'b0;
        stepCycle("memWait.idle");

        iMemReqM = 1'b1; iMemReadyM = 1'b0; iPCSrcE = 1'b1;
        for (int i = 0; i < 2; i++) stepCycle("stallOverBranch.held");
        iMemReadyM = 1'b1;
        stepCycle("stallOverBranch.flushAfter");
        clearInputs();

        iMemReqM = 1'b1; iMemReadyM = 1'b0;
        stepCycle("midWait.enter");
        stepCycle("midWait.wait");
        pulseReset("midWait.reset");
        iMemReqM = 1'b0;
        stepCycle("midWait.idleAfterReset");

        iMemReqM = 1'b1; iMemReadyM = 1'b0;
        for (int i = 0; i < TIMEOUT + 2; i++) stepCycle("timeout.waiting");
        iMemReadyM = 1'b1; iMemReqM = 1'b0;
        stepCycle("timeout.sticky");
        stepCycle("timeout.stickyAgain");
        pulseReset("timeout.reset");
        stepCycle("timeout.cleared");

        for (int i = 0; i < 600; i++) begin
            applyStimulus();
            stepCycle("random");
            if (i % 75 == 74) pulseReset("random.reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
